// File: rtl/skyline_layer.sv
// skyline_layer: per-pixel building silhouette for one parallax layer.
// Heights come from a 9-bit LFSR (x^9+x^5+1), one value per building column.
// A per-frame scroll phase shifts the pattern left by one pixel every
// SCROLL_DIV frames. hit/window are registered, one cycle after pix_en.
// Optional feature macro: SKYLINE_WINDOWS_EN (lit-window flag on 'window').
module skyline_layer #(
   parameter int         COL_W_LOG2 = 3,
   parameter int         SCROLL_DIV = 1,
   parameter logic [8:0] LFSR_SEED  = 9'h1ff,
   parameter int         ROOF_TOP   = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       line_start,
   input  logic       frame_start,
   input  logic       pix_en,
   input  logic [9:0] vcount,
   output logic       hit,
   output logic       window
);

   // A zero seed would lock the LFSR, so it is replaced by all-ones.
   localparam logic [8:0] SEED      = (LFSR_SEED == 9'd0) ? 9'h1ff : LFSR_SEED;
   localparam logic [7:0] DIV_LAST  = 8'(SCROLL_DIV - 1);
   localparam logic [9:0] ROOF_BASE = 10'(ROOF_TOP);

   function automatic logic [8:0] lfsr_step(input logic [8:0] l);
      return {l[7:0], l[8] ^ l[4]};
   endfunction

   // Frame snapshot: LFSR value and sub-column offset at the left edge.
   logic [8:0]            snap_lfsr_q, snap_lfsr_d;
   logic [COL_W_LOG2-1:0] snap_phase_q, snap_phase_d;
   logic [7:0]            div_cnt_q, div_cnt_d;
   // Line state: walks across the row one pixel at a time.
   logic [8:0]            lfsr_q, lfsr_d;
   logic [COL_W_LOG2-1:0] col_cnt_q, col_cnt_d;
   logic                  hit_q, hit_d;
   logic [9:0]            roof;

   // Roof row of the current building, from the pre-step LFSR value.
   always_comb begin
      roof = ROOF_BASE + {2'b00, lfsr_q[3:0], 4'b0000};
   end

   // Scroll update on frame_start; independent of any same-cycle line load.
   always_comb begin
      snap_lfsr_d  = snap_lfsr_q;
      snap_phase_d = snap_phase_q;
      div_cnt_d    = div_cnt_q;
      if (frame_start) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d    = 8'd0;
            snap_phase_d = snap_phase_q + COL_W_LOG2'(1);
            // Phase wrapping means the whole column scrolled off the edge.
            if (&snap_phase_q)
               snap_lfsr_d = lfsr_step(snap_lfsr_q);
         end else begin
            div_cnt_d = div_cnt_q + 8'd1;
         end
      end
   end

   // Line walk: load from the (pre-update) snapshot, else advance per pixel.
   always_comb begin
      lfsr_d    = lfsr_q;
      col_cnt_d = col_cnt_q;
      if (line_start) begin
         lfsr_d    = snap_lfsr_q;
         col_cnt_d = snap_phase_q;
      end else if (pix_en) begin
         col_cnt_d = col_cnt_q + COL_W_LOG2'(1);
         if (&col_cnt_q)
            lfsr_d = lfsr_step(lfsr_q);
      end
   end

   // Coverage compare for the pixel presented this cycle.
   always_comb begin
      hit_d = pix_en && (vcount >= roof);
   end

   // All state flops, asynchronously reset to the seed / zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_lfsr_q  <= SEED;
         snap_phase_q <= '0;
         div_cnt_q    <= 8'd0;
         lfsr_q       <= SEED;
         col_cnt_q    <= '0;
         hit_q        <= 1'b0;
      end else begin
         snap_lfsr_q  <= snap_lfsr_d;
         snap_phase_q <= snap_phase_d;
         div_cnt_q    <= div_cnt_d;
         lfsr_q       <= lfsr_d;
         col_cnt_q    <= col_cnt_d;
         hit_q        <= hit_d;
      end
   end

   assign hit = hit_q;

`ifdef SKYLINE_WINDOWS_EN
   logic window_q, window_d;

   // Two-pixel window columns in alternate 4-row bands, 4 rows below roof.
   always_comb begin
      window_d = pix_en && (vcount >= (roof + 10'd4)) && lfsr_q[4]
                 && col_cnt_q[1] && vcount[2];
   end

   // Window flag register, aligned with hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) window_q <= 1'b0;
      else     window_q <= window_d;
   end

   assign window = window_q;
`else
   assign window = 1'b0;
`endif

endmodule

// File: tb/tb_skyline_layer.sv
// tb_skyline_layer: directed checks of skyline_layer with hand-computed
// expectations. dut uses defaults (SCROLL_DIV=1); dut2 uses SCROLL_DIV=2.
module tb_skyline_layer;

   logic       clk = 1'b0;
   logic       rst;
   logic       line_start, frame_start, pix_en;
   logic [9:0] vcount;
   logic       hit, window, hit2, window2;

   int vec_cnt = 0;
   int err_cnt = 0;

`ifdef SKYLINE_WINDOWS_EN
   localparam logic [16:0] WIN_EXP = 17'h000cc;
`else
   localparam logic [16:0] WIN_EXP = 17'h00000;
`endif

   skyline_layer dut (
      .clk(clk), .rst(rst), .line_start(line_start), .frame_start(frame_start),
      .pix_en(pix_en), .vcount(vcount), .hit(hit), .window(window));

   skyline_layer #(.SCROLL_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .line_start(line_start), .frame_start(frame_start),
      .pix_en(pix_en), .vcount(vcount), .hit(hit2), .window(window2));

   always #5 clk = ~clk;

   // Async reset held for a few cycles, released away from the clock edge.
   task automatic do_reset();
      rst = 1'b1; line_start = 0; frame_start = 0; pix_en = 0; vcount = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 frame_start = 1'b1;
         @(posedge clk); #1 frame_start = 1'b0;
      end
   endtask

   // One line: line_start, then npix pixels. Bit i = output for pixel i,
   // bit npix = output the cycle after the last pixel (must be 0).
   task automatic run_line(input logic [9:0] row, input int npix,
                           output logic [16:0] hits, output logic [16:0] wins,
                           output logic [16:0] hits2);
      hits = '0; wins = '0; hits2 = '0;
      @(posedge clk); #1 vcount = row; line_start = 1'b1; pix_en = 1'b0;
      @(posedge clk); #1 line_start = 1'b0;
      for (int i = 0; i < npix; i++) begin
         pix_en = 1'b1;
         @(posedge clk); #1;
         hits[i] = hit; wins[i] = window; hits2[i] = hit2;
      end
      pix_en = 1'b0;
      @(posedge clk); #1;
      hits[npix] = hit; wins[npix] = window; hits2[npix] = hit2;
   endtask

   task automatic test_reset();
      rst = 1'b1; line_start = 0; frame_start = 0; pix_en = 0; vcount = '0;
      #1;
      vec_cnt++; if (hit !== 1'b0) begin err_cnt++; $display("FAIL reset_hit got %b want 0", hit); end
      vec_cnt++; if (window !== 1'b0) begin err_cnt++; $display("FAIL reset_window got %b want 0", window); end
      vec_cnt++; if (dut.lfsr_q !== 9'h1ff) begin err_cnt++; $display("FAIL reset_lfsr got %h want 1ff", dut.lfsr_q); end
      vec_cnt++; if (dut.snap_lfsr_q !== 9'h1ff) begin err_cnt++; $display("FAIL reset_snap_lfsr got %h want 1ff", dut.snap_lfsr_q); end
      vec_cnt++; if ({dut.col_cnt_q, dut.snap_phase_q, dut.div_cnt_q} !== 14'd0) begin err_cnt++;
         $display("FAIL reset_counters got %h/%h/%h want 0", dut.col_cnt_q, dut.snap_phase_q, dut.div_cnt_q); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_roof();
      logic [16:0] h, w, h2;
      run_line(10'd367, 8, h, w, h2);
      vec_cnt++; if (h !== 17'h0) begin err_cnt++; $display("FAIL roof_367 got %h want 0", h); end
      run_line(10'd368, 8, h, w, h2);
      vec_cnt++; if (h !== 17'h0ff) begin err_cnt++; $display("FAIL roof_368 got %h want 0ff", h); end
      vec_cnt++; if (h2 !== 17'h0ff) begin err_cnt++; $display("FAIL roof_368_dut2 got %h want 0ff", h2); end
   endtask

   task automatic test_column_step();
      logic [16:0] h, w, h2;
      run_line(10'd352, 16, h, w, h2);
      vec_cnt++; if (h !== 17'h0ff00) begin err_cnt++; $display("FAIL column_step got %h want 0ff00", h); end
   endtask

   task automatic test_windows();
      logic [16:0] h, w, h2;
      run_line(10'd380, 8, h, w, h2);
      vec_cnt++; if (h !== 17'h0ff) begin err_cnt++; $display("FAIL win_380_hit got %h want 0ff", h); end
      vec_cnt++; if (w !== WIN_EXP) begin err_cnt++; $display("FAIL win_380 got %h want %h", w, WIN_EXP); end
      run_line(10'd372, 8, h, w, h2);
      vec_cnt++; if (w !== WIN_EXP) begin err_cnt++; $display("FAIL win_372 got %h want %h", w, WIN_EXP); end
      run_line(10'd376, 8, h, w, h2);
      vec_cnt++; if (w !== 17'h0) begin err_cnt++; $display("FAIL win_376_band got %h want 0", w); end
      run_line(10'd371, 8, h, w, h2);
      vec_cnt++; if (w !== 17'h0) begin err_cnt++; $display("FAIL win_371 got %h want 0", w); end
   endtask

   task automatic test_scroll();
      logic [16:0] h, w, h2;
      do_reset();
      frames(2);
      vec_cnt++; if (dut2.snap_phase_q !== 3'd1 || dut2.div_cnt_q !== 8'd0) begin err_cnt++;
         $display("FAIL scroll2_phase got %h/%h want 1/0", dut2.snap_phase_q, dut2.div_cnt_q); end
      vec_cnt++; if (dut.snap_phase_q !== 3'd2) begin err_cnt++; $display("FAIL scroll1_phase got %h want 2", dut.snap_phase_q); end
      run_line(10'd352, 16, h, w, h2);
      // dut2: first building 7 pixels wide; dut: 6 pixels wide.
      vec_cnt++; if (h2 !== 17'h0ff80) begin err_cnt++; $display("FAIL scroll2_line got %h want 0ff80", h2); end
      vec_cnt++; if (h !== 17'h0ffc0) begin err_cnt++; $display("FAIL scroll1_line got %h want 0ffc0", h); end
      frames(14); // 16 frames in total since reset
      vec_cnt++; if (dut2.snap_lfsr_q !== 9'h1fe || dut2.snap_phase_q !== 3'd0) begin err_cnt++;
         $display("FAIL scroll2_16f got %h/%h want 1fe/0", dut2.snap_lfsr_q, dut2.snap_phase_q); end
      vec_cnt++; if (dut.snap_lfsr_q !== 9'h1fc || dut.snap_phase_q !== 3'd0) begin err_cnt++;
         $display("FAIL scroll1_16f got %h/%h want 1fc/0", dut.snap_lfsr_q, dut.snap_phase_q); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      frames(7); // dut snapshot: lfsr 1ff, phase 7
      @(posedge clk); #1 vcount = 10'd352; line_start = 1; frame_start = 1; pix_en = 1;
      @(posedge clk); #1 line_start = 0; frame_start = 0; pix_en = 0;
      vec_cnt++; if (dut.lfsr_q !== 9'h1ff || dut.col_cnt_q !== 3'd7) begin err_cnt++;
         $display("FAIL simul_load got %h/%h want 1ff/7", dut.lfsr_q, dut.col_cnt_q); end
      vec_cnt++; if (dut.snap_lfsr_q !== 9'h1fe || dut.snap_phase_q !== 3'd0 || dut.div_cnt_q !== 8'd0) begin err_cnt++;
         $display("FAIL simul_frame got %h/%h/%h want 1fe/0/0", dut.snap_lfsr_q, dut.snap_phase_q, dut.div_cnt_q); end
      pix_en = 1;
      @(posedge clk); #1 pix_en = 0;
      vec_cnt++; if (dut.lfsr_q !== 9'h1fe || dut.col_cnt_q !== 3'd0) begin err_cnt++;
         $display("FAIL simul_next_pix got %h/%h want 1fe/0", dut.lfsr_q, dut.col_cnt_q); end
   endtask

   task automatic test_reset_midline();
      logic [16:0] h, w, h2;
      do_reset();
      @(posedge clk); #1 vcount = 10'd400; line_start = 1;
      @(posedge clk); #1 line_start = 0; pix_en = 1;
      @(posedge clk); #1;
      vec_cnt++; if (hit !== 1'b1) begin err_cnt++; $display("FAIL midline_pre got %b want 1", hit); end
      #2 rst = 1'b1;
      #1;
      vec_cnt++; if (hit !== 1'b0 || window !== 1'b0) begin err_cnt++;
         $display("FAIL midline_rst got %b%b want 00", hit, window); end
      pix_en = 0;
      @(posedge clk); #1 rst = 1'b0;
      run_line(10'd368, 8, h, w, h2);
      vec_cnt++; if (h !== 17'h0ff) begin err_cnt++; $display("FAIL midline_after got %h want 0ff", h); end
   endtask

   initial begin
      test_reset();
      test_roof();
      test_column_step();
      test_windows();
      test_scroll();
      test_simultaneous();
      test_reset_midline();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/skyline_layer.md
# skyline_layer

Generates the building-silhouette coverage for one parallax layer of the scrolling city scene. It sits between the VGA timing generator and the pixel colour/compositing stage. Timing strobes and the current row go in; a registered per-pixel "inside building" flag, plus an optional lit-window flag, come out for the compositor to colour. Building heights come from a 9-bit LFSR. A per-frame scroll phase shifts the pattern left so that several instances at different rates produce parallax.

## Interface
- `COL_W_LOG2`, default 3: building column width is 2^COL_W_LOG2 pixels.
- `SCROLL_DIV`, default 1: frames per 1-pixel scroll step. Range 1..255.
- `LFSR_SEED`, default 9'h1ff: initial LFSR state. A value of 0 is replaced by 9'h1ff.
- `ROOF_TOP`, default 128: lowest roof row, used for height code 0.
- `clk`, input, 1: pixel clock. All state is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `line_start`, input, 1: one-cycle pulse, at least one cycle before the first visible pixel of each line.
- `frame_start`, input, 1: one-cycle pulse, once per frame, during vertical blanking.
- `pix_en`, input, 1: high for each visible pixel.
- `vcount`, input, 10: current row, 0..479 while visible, stable through the line.
- `hit`, output, 1: pixel lies inside a building. Registered.
- `window`, output, 1: pixel is a lit window. Registered. Held 0 when the feature is compiled out.

## Operation
- LFSR step function: `l <= {l[7:0], l[8]^l[4]}` (x^9+x^5+1).
- Frame state:
  - `snap_lfsr[8:0]` is the LFSR value at the left screen edge.
  - `snap_phase[COL_W_LOG2-1:0]` is the sub-column offset.
  - `div_cnt[7:0]` counts frames toward the next scroll step.
- On `frame_start`:
  - If `div_cnt==SCROLL_DIV-1`: `div_cnt<=0` and `snap_phase<=snap_phase+1`. If `snap_phase` was all-ones, `snap_lfsr` also steps.
  - Otherwise `div_cnt` increments.
- Line state is `lfsr[8:0]` and `col_cnt`. On `line_start`: `lfsr<=snap_lfsr`, `col_cnt<=snap_phase`.
- On each `pix_en` cycle without `line_start`:
  - `col_cnt` increments, wrapping.
  - When `col_cnt` is all-ones, `lfsr` steps, so the next pixel starts a new building.
- Roof row: `roof = ROOF_TOP + {lfsr[3:0], 4'b0000}`, giving 16-row steps from ROOF_TOP to ROOF_TOP+240. Computed at 10 bits from the current, pre-step `lfsr`.
- `hit <= pix_en && (vcount >= roof)`, registered every cycle.
- Simultaneous events:
  - `line_start` and `pix_en` together: the load wins and the count step is dropped.
  - `line_start` and `frame_start` together: the line loads the pre-update snapshot, and the frame update still occurs.
- The pattern is fully deterministic: identical strobe sequences after reset give identical output.

## Timing
- Latency from `pix_en`/`vcount` to `hit`/`window` is 1 cycle. The compositor must delay its own visible flag by one cycle to match.
- Throughput is one pixel per clock, with no stalls.
- Reset values:
  - `hit=0`, `window=0`.
  - `lfsr=snap_lfsr=LFSR_SEED` (or 9'h1ff if the seed is 0).
  - `col_cnt=snap_phase=0`, `div_cnt=0`.
- Asserting `rst` mid-line forces both outputs to 0 immediately. After release, output is garbage-free once the next `line_start` arrives, and scrolling restarts from the seed.
- The LFSR never reaches 0 from a nonzero state, so there is no lock-up.

## Configuration
- Macro `SKYLINE_WINDOWS_EN`.
- Defined: `window <= pix_en && (vcount >= roof+4) && lfsr[4] && col_cnt[1] && vcount[2]`. This draws 2-pixel lit window columns in every other 4-row band of buildings whose `lfsr[4]` is set.
- Undefined: `window` is constant 0, and the window compare logic is absent.

## Test plan
- Reset check:
  - Stimulus: assert `rst` with defaults.
  - Required: `hit=0` and `window=0` immediately; internal `lfsr=9'h1ff`.
  - Stimulus: release, then apply `line_start`.
  - Required: first-column roof is 368.
- Roof boundary:
  - Stimulus: `vcount=367`, `line_start`, 8 × `pix_en`.
  - Required: `hit=0` throughout.
  - Stimulus: repeat with `vcount=368`.
  - Required: `hit=1` for 8 cycles, each 1 cycle after its `pix_en`.
- Column step:
  - Stimulus: `vcount=352`, 16 pixels.
  - Required: `hit=0` for pixels 0-7 (roof 368); `hit=1` for pixels 8-15, because `lfsr=9'h1fe` gives roof 352.
- Scroll:
  - Stimulus: `SCROLL_DIV=2`, 2 × `frame_start`.
  - Required: `snap_phase=1`, so the first building is 7 pixels wide.
  - Stimulus: 16 × `frame_start`.
  - Required: `snap_lfsr=9'h1fe`, `snap_phase=0`.
- Simultaneous strobes:
  - Stimulus: `line_start`, `frame_start` and `pix_en` in the same cycle.
  - Required: the line loads the old snapshot, `col_cnt` is not advanced, and the frame update is still applied.
- Windows (`SKYLINE_WINDOWS_EN` defined, seed 9'h1ff):
  - Stimulus: `vcount=380` (bit 2 set, ≥372), first column.
  - Required: `window=1` only on pixels with `col_cnt[1]=1`, i.e. pixels 2, 3, 6, 7.
  - Stimulus: same rows with the macro undefined.
  - Required: `window=0` always.
